// File: rtl/pc_gen_pkg.sv
// Shared types and default configuration for the program-counter generator.
package pc_pkg;
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_e;

  localparam int unsigned PC_XLEN      = 64;
  localparam logic [63:0] PC_RESET_VEC = 64'd0;
  localparam int unsigned PC_INC       = 4;
  localparam int unsigned PC_RAS_DEPTH = 4;
endpackage

// File: rtl/pc_gen_if.sv
// Control/redirect inputs and PC outputs of pc_gen, bundled with master/slave views.
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = PC_XLEN
);
  logic            stall;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            trap;
  logic [XLEN-1:0] trap_vec;
  logic            halt;
  logic            resume;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_next;
  logic            misalign;
  logic            halted;

  modport master (
    output stall, br_taken, br_target, trap, trap_vec, halt, resume, call, ret,
    input  pc_out, pc_next, misalign, halted
  );

  modport slave (
    input  stall, br_taken, br_target, trap, trap_vec, halt, resume, call, ret,
    output pc_out, pc_next, misalign, halted
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry, push+pop replaces the top.
module pc_ras #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_sp;
  logic [PW:0]     r_cnt;
  logic [PW-1:0]   w_top_idx;

  assign w_top_idx = r_sp - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_cnt == (PW+1)'(0));

  // Entry storage; validity is tracked by the counter so no reset is needed here.
  always_ff @(posedge clk) begin
    if (i_push && i_pop) begin
      r_mem[w_top_idx] <= i_data;
    end else if (i_push) begin
      r_mem[r_sp] <= i_data;
    end
  end

  // Stack pointer and saturating occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= PW'(0);
      r_cnt <= (PW+1)'(0);
    end else if (i_push && !i_pop) begin
      r_sp <= r_sp + PW'(1);
      if (r_cnt != (PW+1)'(DEPTH)) begin
        r_cnt <= r_cnt + (PW+1)'(1);
      end
    end else if (i_pop && !i_push) begin
      r_sp  <= r_sp - PW'(1);
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with trap/branch redirect, stall replay and HALT state.
// Optional return-address stack enabled by macro PC_RAS_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC),
  parameter int unsigned     INC       = PC_INC,
  parameter int unsigned     RAS_DEPTH = PC_RAS_DEPTH
) (
  input logic      clk,
  input logic      reset,
  pc_gen_if.slave  bus
);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  pc_state_e       r_state, w_state_d;
  logic [XLEN-1:0] r_pc, w_pc_d;
  logic [XLEN-1:0] r_pend_tgt, w_pend_tgt_d;
  logic            r_pend_v, w_pend_v_d;
  logic            r_misalign, w_misalign_d;
  logic [XLEN-1:0] w_inc_pc;
  logic            w_br_misalign;
  logic            w_ras_pop;
  logic [XLEN-1:0] w_ras_top;

  assign w_inc_pc      = r_pc + XLEN'(INC);
  assign w_br_misalign = |(bus.br_target & ALIGN_MASK);

`ifdef PC_RAS_EN
  logic w_ras_push, w_ras_empty, w_ras_ok;

  // Stack traffic only when the PC is actually moving this cycle in RUN.
  assign w_ras_ok   = (r_state == RUN) && !bus.trap && !bus.halt && !bus.stall;
  assign w_ras_push = w_ras_ok && bus.call;
  assign w_ras_pop  = w_ras_ok && bus.ret && !r_pend_v && !bus.br_taken && !w_ras_empty;

  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_ras_push),
    .i_pop   (w_ras_pop),
    .i_data  (w_inc_pc),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty)
  );
`else
  assign w_ras_pop = 1'b0;
  assign w_ras_top = {XLEN{1'b0}};
`endif

  // Next-state, next-PC and pending-redirect selection.
  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_pend_v_d   = r_pend_v;
    w_pend_tgt_d = r_pend_tgt;
    w_misalign_d = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.trap) begin
          w_pc_d     = bus.trap_vec;
          w_pend_v_d = 1'b0;
        end else if (bus.halt) begin
          w_state_d = HALT;
        end else if (r_pend_v && !bus.stall) begin
          w_pc_d     = r_pend_tgt;
          w_pend_v_d = 1'b0;
        end else if (bus.br_taken) begin
          // A misaligned target is discarded: flag it, drop any pending one, keep sequencing.
          if (w_br_misalign) begin
            w_misalign_d = 1'b1;
            w_pend_v_d   = 1'b0;
            w_pc_d       = bus.stall ? r_pc : w_inc_pc;
          end else if (bus.stall) begin
            w_pend_v_d   = 1'b1;
            w_pend_tgt_d = bus.br_target;
          end else begin
            w_pc_d = bus.br_target;
          end
        end else if (w_ras_pop) begin
          w_pc_d = w_ras_top;
        end else if (!bus.stall) begin
          w_pc_d = w_inc_pc;
        end else begin
          w_pc_d = r_pc;
        end
      end
      HALT: begin
        if (bus.trap) begin
          w_pc_d     = bus.trap_vec;
          w_pend_v_d = 1'b0;
          w_state_d  = RUN;
        end else if (bus.resume && !bus.halt) begin
          w_state_d = RUN;
        end else begin
          w_state_d = HALT;
        end
      end
      default: begin
        w_state_d = RUN;
      end
    endcase
  end

  // State, PC and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_VEC;
      r_pend_v   <= 1'b0;
      r_pend_tgt <= {XLEN{1'b0}};
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_pend_v   <= w_pend_v_d;
      r_pend_tgt <= w_pend_tgt_d;
      r_misalign <= w_misalign_d;
    end
  end

  assign bus.pc_out   = r_pc;
  assign bus.pc_next  = w_inc_pc;
  assign bus.misalign = r_misalign;
  assign bus.halted   = (r_state == HALT);
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a cycle-level reference model predicts each post-edge state.
module tb_pc_gen;
  localparam int unsigned XLEN      = 64;
  localparam logic [63:0] RESET_VEC = 64'h1000;
  localparam int unsigned INC       = 4;
  localparam int unsigned RAS_DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  typedef struct {
    logic [63:0] pc;
    logic        mis;
    logic        hlt;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN(XLEN), .RESET_VEC(RESET_VEC), .INC(INC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [63:0] m_pc = 64'd0;
  bit          m_halted = 1'b0;
  bit          m_pend_v = 1'b0;
  logic [63:0] m_pend_t = 64'd0;
  logic [63:0] m_ras[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at negedge, advance the model at posedge, queue expectation.
  task automatic cycle(input string tag, input bit rst, input bit st, input bit br,
                       input logic [63:0] bt, input bit tr, input logic [63:0] tv,
                       input bit hl, input bit rs, input bit cl, input bit rt);
    bit          mis;
    bit          do_call, do_ret;
    logic [63:0] seq, rtgt;
    exp_t        e;
    reset = rst; bus.stall = st; bus.br_taken = br; bus.br_target = bt;
    bus.trap = tr; bus.trap_vec = tv; bus.halt = hl; bus.resume = rs;
    bus.call = cl; bus.ret = rt;
    @(posedge clk);
    mis  = 1'b0;
    seq  = m_pc + 64'(INC);
    rtgt = 64'd0;
    if (rst) begin
      m_pc = RESET_VEC; m_halted = 1'b0; m_pend_v = 1'b0; m_ras.delete();
    end else if (m_halted) begin
      if (tr) begin
        m_pc = tv; m_halted = 1'b0; m_pend_v = 1'b0;
      end else if (rs && !hl) begin
        m_halted = 1'b0;
      end
    end else if (tr) begin
      m_pc = tv; m_pend_v = 1'b0;
    end else if (hl) begin
      m_halted = 1'b1;
    end else begin
      do_call = RAS && cl && !st;
      do_ret  = RAS && rt && !st && !m_pend_v && !br && (m_ras.size() > 0);
      if (do_ret) rtgt = m_ras[m_ras.size()-1];
      if (do_call && do_ret) begin
        m_ras[m_ras.size()-1] = seq;
      end else if (do_call) begin
        m_ras.push_back(seq);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (do_ret) begin
        void'(m_ras.pop_back());
      end
      if (m_pend_v && !st) begin
        m_pc = m_pend_t; m_pend_v = 1'b0;
      end else if (br && (bt % INC != 0)) begin
        mis = 1'b1; m_pend_v = 1'b0;
        if (!st) m_pc = seq;
      end else if (br && st) begin
        m_pend_v = 1'b1; m_pend_t = bt;
      end else if (br) begin
        m_pc = bt;
      end else if (do_ret) begin
        m_pc = rtgt;
      end else if (!st) begin
        m_pc = seq;
      end
    end
    e.pc = m_pc; e.mis = mis; e.hlt = m_halted; e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 64'd0, 0, 64'd0, 0, 0, 0, 0);
  endtask

  task automatic stall_br(input string tag, input logic [63:0] bt);
    cycle(tag, 0, 1, 1, bt, 0, 64'd0, 0, 0, 0, 0);
  endtask

  task automatic do_trap(input string tag, input logic [63:0] tv);
    cycle(tag, 0, 0, 0, 64'd0, 1, tv, 0, 0, 0, 0);
  endtask

  // Monitor: every negedge following a driven edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, " pc_out"}, bus.pc_out, e.pc);
        check({e.tag, " pc_next"}, bus.pc_next, e.pc + 64'(INC));
        check({e.tag, " misalign"}, {63'd0, bus.misalign}, {63'd0, e.mis});
        check({e.tag, " halted"}, {63'd0, bus.halted}, {63'd0, e.hlt});
      end
    end
  end

  initial begin
    reset = 1'b1; bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = 64'd0;
    bus.trap = 1'b0; bus.trap_vec = 64'd0; bus.halt = 1'b0; bus.resume = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0;
    @(negedge clk);

    cycle("reset", 1, 0, 0, 64'd0, 0, 64'd0, 0, 0, 0, 0);
    repeat (3) idle("free_run");

    stall_br("stall_br_2000", 64'h2000);
    cycle("stall2", 0, 1, 0, 64'd0, 0, 64'd0, 0, 0, 0, 0);
    cycle("stall3", 0, 1, 0, 64'd0, 0, 64'd0, 0, 0, 0, 0);
    idle("replay_2000");
    idle("after_replay");

    cycle("stall_br_trap", 0, 1, 1, 64'h3000, 1, 64'h8000, 0, 0, 0, 0);
    stall_br("latch_3000", 64'h3000);
    cycle("trap_clears_pend", 0, 1, 0, 64'd0, 1, 64'h8000, 0, 0, 0, 0);
    idle("no_stale_replay");

    cycle("br_misalign", 0, 0, 1, 64'h2002, 0, 64'd0, 0, 0, 0, 0);
    idle("misalign_clears");

    stall_br("pend_4000", 64'h4000);
    stall_br("pend_over_5000", 64'h5000);
    idle("replay_5000");
    stall_br("pend_6000", 64'h6000);
    stall_br("stall_misalign", 64'h6001);
    idle("pend_dropped");

    do_trap("trap_top", 64'hFFFF_FFFF_FFFF_FFF8);
    idle("near_wrap");
    idle("wrap_to_zero");
    idle("after_wrap");
    cycle("halt", 0, 0, 0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    cycle("halt_resume_both", 0, 0, 0, 64'd0, 0, 64'd0, 1, 1, 0, 0);
    cycle("halt_ignore_br", 0, 0, 1, 64'h7000, 0, 64'd0, 0, 0, 0, 0);
    idle("halt_idle");
    cycle("resume", 0, 0, 0, 64'd0, 0, 64'd0, 0, 1, 0, 0);
    idle("run_after_resume");
    cycle("halt2", 0, 0, 0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    do_trap("trap_in_halt", 64'h9000);
    idle("run_after_trap");

    stall_br("pend_A000", 64'hA000);
    cycle("reset_mid_stall", 1, 1, 1, 64'hB000, 0, 64'd0, 0, 0, 0, 0);
    idle("no_pend_after_reset");
    cycle("halt3", 0, 0, 0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    cycle("reset_in_halt", 1, 0, 0, 64'd0, 0, 64'd0, 0, 0, 0, 0);
    idle("run_after_reset");

    do_trap("trap_100", 64'h100);
    for (int i = 0; i < 5; i++) begin
      cycle("call_br", 0, 0, 1, 64'h200 + 64'(i) * 64'h100, 0, 64'd0, 0, 0, 1, 0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle("ret", 0, 0, 0, 64'd0, 0, 64'd0, 0, 0, 0, 1);
    end
    cycle("call_ret", 0, 0, 0, 64'd0, 0, 64'd0, 0, 0, 1, 1);
    cycle("call_ret2", 0, 0, 0, 64'd0, 0, 64'd0, 0, 0, 1, 1);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] bt, tv;
      bt = {$urandom, $urandom};
      tv = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) bt[1:0] = 2'b00;
      tv[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) bt[63:16] = 48'd0;
      cycle("random", $urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, bt, $urandom_range(0, 15) == 0, tv,
            $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 64, PC and target width in bits.
REQ-002 Parameter RESET_VEC, default 64'd0 (XLEN bits), PC value loaded by reset.
REQ-003 Parameter INC, default 4, sequential increment in bytes, power of two.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, at least 2.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  stall  in  1  hold PC (hazard unit)
  br_taken  in  1  branch/jump redirect request
  br_target  in  XLEN  redirect target
  trap  in  1  trap redirect, highest non-reset priority
  trap_vec  in  XLEN  trap target
  halt  in  1  enter HALT state
  resume  in  1  leave HALT state
  call  in  1  push return address (PC_RAS_EN only)
  ret  in  1  pop and redirect (PC_RAS_EN only)
  pc_out  out  XLEN  current PC
  pc_next  out  XLEN  combinational pc_out+INC
  misalign  out  1  one-cycle pulse, rejected misaligned target
  halted  out  1  high in HALT state

Function
REQ-006 States RUN, HALT; reset enters RUN.
REQ-007 RUN per-cycle priority: trap > pending-redirect replay > br_taken > stall > pc_out+INC.
REQ-008 trap SHALL load trap_vec next cycle regardless of stall; it clears pending redirect.
REQ-009 br_taken while stall=1 SHALL latch br_target into a one-entry pending register; PC holds.
REQ-010 A pending redirect SHALL be applied on the first cycle with stall=0, then cleared.
REQ-011 A later br_taken during the same stall SHALL overwrite the pending target.
REQ-012 Targets with low log2(INC) bits nonzero SHALL NOT load; misalign pulses the next cycle; PC advances as if no redirect; pending is dropped.
REQ-013 Addition SHALL wrap modulo 2^XLEN; all-ones-aligned PC+INC wraps to 0.
REQ-014 halt in RUN SHALL move to HALT next cycle; PC frozen; halted=1.
REQ-015 In HALT, only trap or resume leave: trap loads trap_vec and enters RUN; resume enters RUN with PC unchanged.
REQ-016 halt and resume both high in HALT SHALL stay in HALT.
REQ-017 Redirect latency is one cycle: request at edge N, pc_out equals target after edge N+1.

Reset
REQ-018 On reset: pc_out=RESET_VEC, state RUN, pending cleared, misalign=0, halted=0, RAS emptied.
REQ-019 Reset SHALL override every input in the same cycle, including mid-stall and HALT.

Configuration
REQ-020 Macro PC_RAS_EN. Defined: call pushes pc_out+INC; ret redirects to the top entry and pops it, with br_taken priority.
REQ-021 RAS full push SHALL overwrite the oldest entry (circular); ret on empty SHALL be ignored.
REQ-022 call and ret together SHALL redirect to the top entry and replace it with pc_out+INC.
REQ-023 Undefined: call/ret ignored, no RAS storage synthesised.

Structure
REQ-024 Package pc_pkg holds the state enum (RUN, HALT) and the default XLEN/RESET_VEC/INC constants.
REQ-025 Sub-module pc_ras (the circular stack, pointer and count), instantiated only under PC_RAS_EN.

Verification
REQ-026 Reset with RESET_VEC=0x1000, then 3 free cycles -> pc_out 0x1000, 0x1004, 0x1008, 0x100C.
REQ-027 stall=1 for 3 cycles; br_taken with target 0x2000 in cycle 1 -> PC holds; pc_out=0x2000 one cycle after stall drops.
REQ-028 br_taken and trap together (target 0x3000, trap_vec 0x8000) while stalled -> pc_out=0x8000 next cycle; pending cleared.
REQ-029 br_target=0x2002 -> misalign pulse for 1 cycle; pc_out advances by 4.
REQ-030 pc_out=0xFFFF_FFFF_FFFF_FFFC, free run -> 0x0; halt then resume -> PC frozen while halted=1.
REQ-031 PC_RAS_EN, depth 4: 5 calls at 0x100, 0x200, 0x300, 0x400, 0x500, then 5 rets -> targets 0x504, 0x404, 0x304, 0x204, then ignored.
